pim_output_drain_buffer: RTL and testbench
==========================================

# pim_output_drain_buffer

Parametrised, double-banked output buffer between the eFlash PIM macro's ADC output word and the peripheral load path. It captures a full PIM output word, optionally applies a saturating signed zero-point offset per group, and drains the result over a valid/ready stream. In parallel and row-by-row modes it drains all groups; in read mode it drains one selected group. Two banks let the next capture land while the previous one is still draining.

## Interface
- `NUM_GROUPS`, default 32: groups per PIM output word; power of two, at least 2.
- `GROUP_W`, default 32: bits per group and per output beat.
- `IDX_W`, default `$clog2(NUM_GROUPS)`: group index width (derived).
- `clk_i`  in  1: the single clock.
- `rst_ni`  in  1: reset, synchronous, active-low.
- `pim_output_i`  in  NUM_GROUPS*GROUP_W: raw PIM output word. Group i is `pim_output_i[GROUP_W*(NUM_GROUPS-i)-1 -: GROUP_W]`, so group 0 is the MSB slice.
- `cap_valid_i`  in  1: capture request.
- `cap_ready_o`  out  1: a bank is free.
- `cap_mode_i`  in  3: mode for this capture (PIM_READ, PIM_PARALLEL or PIM_RBR).
- `col_sel_i`  in  IDX_W: group to emit in read mode; sampled at capture.
- `zp_en_i`  in  1: apply the zero point to this capture.
- `zp_data_i`  in  GROUP_W: signed zero point; sampled at capture.
- `flush_i`  in  1: discard all stored and draining data.
- `out_valid_o`  out  1: output beat valid.
- `out_ready_i`  in  1: consumer accepts the beat.
- `out_data_o`  out  GROUP_W: beat data.
- `out_idx_o`  out  IDX_W: group index of the beat.
- `out_last_o`  out  1: final beat of the current capture.
- `mode_err_o`  out  1: one-cycle pulse when a capture carries an illegal mode.
- `busy_o`  out  1: at least one bank is occupied.

## Operation
- **Storage and pointers.** Two banks. Each bank holds NUM_GROUPS words of GROUP_W bits, a mode, a selected index and an occupied flag. A 1-bit write pointer selects the bank for the next capture; a 1-bit read pointer selects the bank being drained. Banks drain in capture order.
- **Capture.** A capture is `cap_valid_i && cap_ready_o`. It writes bank[wr_ptr], sets that bank's occupied flag and toggles wr_ptr.
- **Zero-point adjust.** When `zp_en_i` is high, each group is stored as `sat(group + zp_data_i)`, a signed add clamped to `[-2^(GROUP_W-1), 2^(GROUP_W-1)-1]`. When `zp_en_i` is low, groups are stored unchanged.
- **Illegal mode.** A capture whose mode is not PIM_READ (3'b011), PIM_PARALLEL (3'b101) or PIM_RBR (3'b110) is accepted but nothing is stored. `mode_err_o` pulses on the cycle after the capture handshake, and the pointers do not move.
- **Drain FSM states:**
  - IDLE → DRAIN when bank[rd_ptr] is occupied. The beat counter is loaded with 0 (parallel/RBR) or with `col_sel` (read).
  - DRAIN: `out_valid_o` = 1. A beat is `out_valid_o && out_ready_i`.
  - Parallel/RBR: each beat increments `out_idx_o`. The beat at idx NUM_GROUPS-1 carries `out_last_o` = 1.
  - Read: exactly one beat, with `out_last_o` = 1.
  - On the last beat: clear the bank's occupied flag, toggle rd_ptr, then go to DRAIN again if the other bank is occupied, otherwise to IDLE.
- **Flush.** `flush_i` clears both occupied flags and both pointers and sends the FSM to IDLE. It wins over a capture in the same cycle; that capture is dropped.

## Timing
- **Reset.** While `rst_ni` = 0 at a clock edge, every register clears. After the reset edge, every output is 0; `cap_ready_o` is 0 while `rst_ni` is low and 1 after release.
- **Capture-to-output latency.** `out_valid_o` rises on the cycle after capture into an empty buffer (latency 1). No bubble occurs between back-to-back captures draining.
- **`cap_ready_o`.** Equals `rst_ni && !(occ[0] && occ[1])`. It is decoded from registered flags only, with no combinational path from `out_ready_i`. When the last beat completes in the same cycle as a stalled capture, `cap_ready_o` rises one cycle later.
- **Output stability.** `out_data_o`, `out_idx_o` and `out_last_o` are held stable while `out_valid_o && !out_ready_i`. They are 0 whenever `out_valid_o` is 0.
- **Simultaneous capture and drain.** A capture into a free bank and a beat from the other bank may occur in the same cycle.
- **Flush and reset mid-drain.** Either one drops `out_valid_o` on the next cycle; no partial beat is completed.
- **`busy_o`.** Equals `occ[0] || occ[1]`, registered.

## Structure
- **Package `pim_out_pkg`:**
  - mode localparams PIM_READ, PIM_PARALLEL, PIM_RBR;
  - `drain_state_e` enum (IDLE, DRAIN);
  - a `pim_mode_legal()` function.
- **Sub-module `pim_zp_sat_add`:** parametrised by GROUP_W; purely combinational signed saturating adder. It is instantiated NUM_GROUPS times in a generate loop.
- **Top level:** holds the bank storage, pointers, occupied flags, the drain FSM and the output mux.

## Test plan
- **Parallel drain.** NUM_GROUPS=32, GROUP_W=32, capture with mode 3'b101 and group i = i, zp off → 32 beats with data 0..31 and idx 0..31, `out_last_o` only on idx 31; `out_valid_o` rises 1 cycle after capture.
- **Read mode with zero point.** Mode 3'b011, col_sel=5, group5 = 0x0000_0010, zp = -3 → exactly one beat, data 0x0000_000D, idx 5, last = 1.
- **Saturation.** group = 0x7FFF_FFF0, zp = +0x100 → 0x7FFF_FFFF; group = 0x8000_0001, zp = -2 → 0x8000_0000.
- **Ping-pong backpressure.** Three back-to-back captures with `out_ready_i` held low → first two accepted, `cap_ready_o` = 0 for the third. Release ready → 64 beats in capture order; `cap_ready_o` returns 1 the cycle after beat 32.
- **Illegal mode.** Capture with mode 3'b000 → `mode_err_o` pulses for one cycle, no output beats, `busy_o` stays 0.
- **Flush and reset.** Flush at beat 10 of a drain, with a concurrent capture → `out_valid_o` = 0 next cycle, `busy_o` = 0, the concurrent capture is lost. Repeat with `rst_ni` low for one edge → all outputs 0.

Source files
------------

// File: rtl/pim_out_pkg.sv
// pim_out_pkg: shared mode encodings, drain FSM states and mode check for the PIM output drain buffer.
package pim_out_pkg;
   localparam logic [2:0] PIM_READ     = 3'b011;
   localparam logic [2:0] PIM_PARALLEL = 3'b101;
   localparam logic [2:0] PIM_RBR      = 3'b110;
   typedef enum logic {IDLE, DRAIN} drain_state_e;
   function automatic logic pim_mode_legal(input logic [2:0] m);
      return (m == PIM_READ) || (m == PIM_PARALLEL) || (m == PIM_RBR);
   endfunction
endpackage

// File: rtl/pim_zp_sat_add.sv
// pim_zp_sat_add: combinational signed add of a group and a zero point, clamped to the GROUP_W signed range.
//   a_i   : signed group value
//   b_i   : signed zero point
//   sum_o : saturated a_i + b_i
module pim_zp_sat_add #(
   parameter int GROUP_W = 32
) (
   input  logic [GROUP_W-1:0] a_i,
   input  logic [GROUP_W-1:0] b_i,
   output logic [GROUP_W-1:0] sum_o
);
   logic [GROUP_W:0] sum;
   assign sum = {a_i[GROUP_W-1], a_i} + {b_i[GROUP_W-1], b_i};
   // The top two bits of the widened sum differ only on overflow; the wider bit gives the true sign.
   assign sum_o = (sum[GROUP_W] != sum[GROUP_W-1])
                ? (sum[GROUP_W] ? {1'b1, {(GROUP_W-1){1'b0}}} : {1'b0, {(GROUP_W-1){1'b1}}})
                : sum[GROUP_W-1:0];
endmodule

// File: rtl/pim_output_drain_buffer.sv
// pim_output_drain_buffer: double-banked capture of a PIM output word with optional zero-point offset, drained as a valid/ready stream.
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   pim_output_i         : raw word, group 0 in the MSB slice
//   cap_valid_i/_ready_o : capture handshake; cap_mode_i, col_sel_i, zp_en_i, zp_data_i sampled with it
//   flush_i              : drop everything stored or draining
//   out_valid_o/_ready_i : beat handshake; out_data_o, out_idx_o, out_last_o describe the beat
//   mode_err_o           : pulse after a capture with an illegal mode
//   busy_o               : a bank is occupied
module pim_output_drain_buffer
   import pim_out_pkg::*;
#(
   parameter int NUM_GROUPS = 32,
   parameter int GROUP_W    = 32,
   parameter int IDX_W      = $clog2(NUM_GROUPS)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_GROUPS*GROUP_W-1:0] pim_output_i,
   input  logic                          cap_valid_i,
   output logic                          cap_ready_o,
   input  logic [2:0]                    cap_mode_i,
   input  logic [IDX_W-1:0]              col_sel_i,
   input  logic                          zp_en_i,
   input  logic [GROUP_W-1:0]            zp_data_i,
   input  logic                          flush_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [GROUP_W-1:0]            out_data_o,
   output logic [IDX_W-1:0]              out_idx_o,
   output logic                          out_last_o,
   output logic                          mode_err_o,
   output logic                          busy_o
);
   logic [GROUP_W-1:0] bank_q [2][NUM_GROUPS];
   logic [GROUP_W-1:0] cap_word [NUM_GROUPS];
   logic [IDX_W-1:0]   sel_q [2];
   logic [1:0]         is_read_q, occ_q, occ_d;
   logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, err_q;
   drain_state_e       state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d, tgt_idx;
   logic               cap_hs, cap_ok, beat, last, tgt, tgt_occ, tgt_read;

   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
      logic [GROUP_W-1:0] raw, adj;
      assign raw = pim_output_i[GROUP_W*(NUM_GROUPS-g)-1 -: GROUP_W];
      pim_zp_sat_add #(.GROUP_W(GROUP_W)) u_sat (.a_i(raw), .b_i(zp_data_i), .sum_o(adj));
      assign cap_word[g] = zp_en_i ? adj : raw;
   end

   assign cap_ready_o = rst_ni && !(occ_q[0] && occ_q[1]);
   assign cap_hs      = cap_valid_i && cap_ready_o;
   assign cap_ok      = cap_hs && pim_mode_legal(cap_mode_i) && !flush_i;
   assign busy_o      = occ_q[0] || occ_q[1];
   assign mode_err_o  = err_q;
   assign out_valid_o = (state_q == DRAIN);
   assign beat        = out_valid_o && out_ready_i;
   assign last        = is_read_q[rd_ptr_q] || (idx_q == IDX_W'(NUM_GROUPS-1));
   assign out_data_o  = out_valid_o ? bank_q[rd_ptr_q][idx_q] : '0;
   assign out_idx_o   = out_valid_o ? idx_q : '0;
   assign out_last_o  = out_valid_o && last;

   // Bank to drain next: the current one from IDLE, the other one after a last beat.
   // A capture landing in that bank this cycle counts, so neither entry nor hand-over costs a bubble.
   assign tgt      = (state_q == DRAIN) ? ~rd_ptr_q : rd_ptr_q;
   assign tgt_occ  = occ_q[tgt] || (cap_ok && (wr_ptr_q == tgt));
   assign tgt_read = occ_q[tgt] ? is_read_q[tgt] : (cap_mode_i == PIM_READ);
   assign tgt_idx  = !tgt_read ? '0 : (occ_q[tgt] ? sel_q[tgt] : col_sel_i);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      occ_d    = occ_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (state_q == IDLE && tgt_occ) begin
         state_d = DRAIN;
         idx_d   = tgt_idx;
      end
      if (beat && last) begin
         occ_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = ~rd_ptr_q;
         state_d         = tgt_occ ? DRAIN : IDLE;
         idx_d           = tgt_idx;
      end else if (beat) begin
         idx_d = idx_q + 1'b1;
      end
      if (cap_ok) begin
         occ_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (flush_i) begin
         state_d  = IDLE;
         occ_d    = '0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         occ_q     <= '0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         err_q     <= 1'b0;
         is_read_q <= '0;
         for (int b = 0; b < 2; b++) begin
            sel_q[b] <= '0;
            for (int i = 0; i < NUM_GROUPS; i++) bank_q[b][i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         occ_q    <= occ_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         err_q    <= cap_hs && !pim_mode_legal(cap_mode_i) && !flush_i;
         if (cap_ok) begin
            is_read_q[wr_ptr_q] <= (cap_mode_i == PIM_READ);
            sel_q[wr_ptr_q]     <= col_sel_i;
            for (int i = 0; i < NUM_GROUPS; i++) bank_q[wr_ptr_q][i] <= cap_word[i];
         end
      end
   end
endmodule

// File: tb/tb_pim_output_drain_buffer.sv
// tb_pim_output_drain_buffer: directed checks of capture, zero point, saturation, ping-pong drain, illegal mode, flush and reset.
module tb_pim_output_drain_buffer;
   localparam int NG = 32;
   localparam int GW = 32;
   localparam int IW = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NG*GW-1:0] pim;
   logic            cap_valid, cap_ready, zp_en, flush, out_valid, out_ready, out_last, mode_err, busy;
   logic [2:0]      cap_mode;
   logic [IW-1:0]   col_sel, out_idx;
   logic [GW-1:0]   zp_data, out_data;
   int              checks = 0;
   int              errors = 0;

   pim_output_drain_buffer #(.NUM_GROUPS(NG), .GROUP_W(GW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .pim_output_i(pim), .cap_valid_i(cap_valid), .cap_ready_o(cap_ready),
      .cap_mode_i(cap_mode), .col_sel_i(col_sel), .zp_en_i(zp_en), .zp_data_i(zp_data), .flush_i(flush),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_idx_o(out_idx),
      .out_last_o(out_last), .mode_err_o(mode_err), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_grp(input int i, input logic [GW-1:0] v);
      pim[GW*(NG-i)-1 -: GW] = v;
   endtask

   task automatic fill(input logic [GW-1:0] base);
      for (int i = 0; i < NG; i++) set_grp(i, base + GW'(i));
   endtask

   task automatic capture(input logic [2:0] m, input logic [IW-1:0] s, input logic z, input logic [GW-1:0] zp);
      cap_mode = m; col_sel = s; zp_en = z; zp_data = zp; cap_valid = 1'b1;
      tick();
      cap_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; pim = '0; cap_valid = 1'b0; cap_mode = 3'b000; col_sel = '0;
      zp_en = 1'b0; zp_data = '0; flush = 1'b0; out_ready = 1'b0;
      tick();
      check("rst_valid", out_valid, 0);
      check("rst_ready", cap_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_data", out_data, 0);
      check("rst_err", mode_err, 0);
      rst_n = 1'b1;
      #1;
      check("rel_ready", cap_ready, 1);

      fill(0);
      capture(3'b101, 0, 1'b0, 0);
      check("par_lat_valid", out_valid, 1);
      check("par_busy", busy, 1);
      out_ready = 1'b1;
      for (int i = 0; i < NG; i++) begin
         check("par_data", out_data, i);
         check("par_idx", out_idx, i);
         check("par_last", out_last, i == NG-1);
         tick();
      end
      check("par_end_valid", out_valid, 0);
      check("par_end_data", out_data, 0);
      check("par_end_busy", busy, 0);

      fill(32'h1000);
      set_grp(5, 32'h0000_0010);
      capture(3'b011, 5, 1'b1, 32'hFFFF_FFFD);
      check("rd_valid", out_valid, 1);
      check("rd_data", out_data, 32'h0000_000D);
      check("rd_idx", out_idx, 5);
      check("rd_last", out_last, 1);
      tick();
      check("rd_one_beat", out_valid, 0);

      set_grp(0, 32'h7FFF_FFF0);
      capture(3'b011, 0, 1'b1, 32'h0000_0100);
      check("sat_pos", out_data, 32'h7FFF_FFFF);
      tick();
      set_grp(1, 32'h8000_0001);
      capture(3'b011, 1, 1'b1, 32'hFFFF_FFFE);
      check("sat_neg", out_data, 32'h8000_0000);
      check("sat_neg_idx", out_idx, 1);
      tick();

      out_ready = 1'b0;
      fill(32'h100);
      cap_mode = 3'b101; zp_en = 1'b0; cap_valid = 1'b1;
      check("pp_rdy_a", cap_ready, 1);
      tick();
      fill(32'h200);
      check("pp_rdy_b", cap_ready, 1);
      tick();
      fill(32'h300);
      check("pp_rdy_c", cap_ready, 0);
      check("pp_busy", busy, 1);
      tick();
      tick();
      check("pp_stall_data", out_data, 32'h100);
      check("pp_stall_idx", out_idx, 0);
      check("pp_stall_ready", cap_ready, 0);
      cap_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 2*NG; k++) begin
         check("pp_valid", out_valid, 1);
         check("pp_data", out_data, (k < NG ? 32'h100 : 32'h200) + 32'(k % NG));
         check("pp_idx", out_idx, k % NG);
         check("pp_last", out_last, (k % NG) == NG-1);
         check("pp_cap_ready", cap_ready, k >= NG);
         tick();
      end
      check("pp_end_valid", out_valid, 0);
      check("pp_end_busy", busy, 0);

      capture(3'b000, 0, 1'b0, 0);
      check("ill_err", mode_err, 1);
      check("ill_busy", busy, 0);
      check("ill_valid", out_valid, 0);
      tick();
      check("ill_err_pulse", mode_err, 0);
      check("ill_valid2", out_valid, 0);
      check("ill_busy2", busy, 0);

      fill(0);
      capture(3'b101, 0, 1'b0, 0);
      for (int i = 0; i < 10; i++) tick();
      check("fl_idx10", out_idx, 10);
      flush = 1'b1; cap_valid = 1'b1; cap_mode = 3'b101;
      tick();
      flush = 1'b0; cap_valid = 1'b0;
      check("fl_valid", out_valid, 0);
      check("fl_busy", busy, 0);
      tick();
      check("fl_lost_valid", out_valid, 0);
      check("fl_lost_busy", busy, 0);

      capture(3'b101, 0, 1'b0, 0);
      for (int i = 0; i < 10; i++) tick();
      check("rs_mid_valid", out_valid, 1);
      rst_n = 1'b0;
      tick();
      check("rs_valid", out_valid, 0);
      check("rs_data", out_data, 0);
      check("rs_idx", out_idx, 0);
      check("rs_last", out_last, 0);
      check("rs_busy", busy, 0);
      check("rs_err", mode_err, 0);
      check("rs_ready", cap_ready, 0);
      rst_n = 1'b1;
      tick();
      check("rs_rel_ready", cap_ready, 1);
      check("rs_rel_valid", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
